rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//   Round-robin arbiter that shares one single-owner resource among 8 requesters.
//   The resource is, for example, the shared data-memory port or the register-file write port.
//   The winner's 3-bit index is registered.
//   The one-hot grant vector is produced by a decoder3to8 instance, with en = busy.
//   Sits between the requesting units and the resource mux select; gnt_id drives the mux.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles one owner may hold the grant (used only with ARB_TIMEOUT_EN)
//   CNT_W           5   width of the hold counter; must hold TIMEOUT_CYCLES-1
// PORTS
//   clk      in   1  single clock; all state changes on rising edge
//   reset    in   1  asynchronous, active-high reset
//   req      in   8  request per requester; held high until served
//   done     in   1  current owner releases the resource (1-cycle pulse or level)
//   gnt      out  8  one-hot grant = decoder3to8(en=busy, in=gnt_id); all-zero when idle
//   gnt_id   out  3  index of current owner; only meaningful while busy=1
//   busy     out  1  1 while in GRANT state
//   timeout  out  1  1-cycle pulse on forced release (constant 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//   Reset values (applied immediately, asynchronously)
//     state=IDLE; busy=0; gnt=8'h00; gnt_id=3'd0; ptr=3'd7; timeout=0; hold counter=0.
//   State: IDLE
//     - Search req starting at index (ptr+1) mod 8, ascending with wrap; first set bit wins.
//     - If any req is set: on the next edge gnt_id<=winner, ptr<=winner, state<=GRANT.
//     - If req==0: stay in IDLE.
//     - done is ignored in IDLE.
//   State: GRANT
//     - busy=1; gnt has exactly one bit set, at gnt_id.
//     - Release condition: done=1 OR req[gnt_id]=0 (requester withdrew).
//     - On release: state<=IDLE.
//     - done and withdrawal in the same cycle count as one release.
//   Latency
//     - First grant is visible 1 cycle after req is sampled in IDLE.
//     - Every release is followed by exactly one cycle with gnt=0 (bus turnaround).
//     - Back-to-back owners are therefore separated by one idle cycle.
//     - Minimum tenure is 1 cycle: done may be high in the first GRANT cycle.
//   Fairness
//     - The pointer advances only when a grant is issued.
//     - A continuously requesting unit waits at most 7 other tenures.
//     - A single sole requester is re-granted after each idle cycle.
//     - ptr=7 at reset means requester 0 has priority first.
//   Boundary conditions
//     - All 8 requesting: grants rotate 0,1,...,7,0 in order.
//     - Winner index 7 followed by a search that wraps to index 0 is legal.
//     - A req that rises during GRANT is not seen until the next IDLE cycle.
//     - Reset mid-GRANT drops gnt and busy at once; the tenure is not resumed.
//     - gnt_id holds its last value in IDLE; the decoder en forces gnt to 0 there.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined
//     - The hold counter clears on entry to GRANT and increments every GRANT cycle.
//     - If no release by the cycle where counter==TIMEOUT_CYCLES-1: forced release, state<=IDLE.
//     - timeout=1 for the following single IDLE cycle.
//     - ptr still points at the evicted owner, so the next search starts after it.
//     - A normal release in the same cycle takes precedence: timeout stays 0.
//   ARB_TIMEOUT_EN undefined
//     - No counter is built; tenure is unbounded.
//     - The timeout port is tied to 0, so the port list is identical in both builds.
// TESTING
//   1. Assert reset mid-run, release it, req=8'h00 for 5 cycles
//      -> gnt=0, busy=0, timeout=0 throughout.
//   2. req=8'h01, done pulsed 3 cycles after grant
//      -> gnt=8'h01 one cycle after req; released; one gnt=0 cycle; re-granted 8'h01.
//   3. req=8'hFF, done each GRANT cycle
//      -> gnt_id sequence 0,1,2,...,7,0; each grant separated by one gnt=0 cycle.
//   4. req=8'h90, with ptr=4 after a prior grant to 4
//      -> next grant 7, then 4 (wrap search), then 7.
//   5. Owner 2 drops req[2] while done=1 in the same cycle -> single release; next grant goes to the next requester.
//   6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req=8'h08, done never asserted
//      -> gnt=8'h08 for exactly 16 cycles; then timeout=1 for 1 cycle with gnt=0.
//      Without the macro: the grant persists and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one single-owner resource shared by 8 requesters.
// The optional ARB_TIMEOUT_EN macro adds a hold counter that evicts long-running owners.

module decoder3to8 (
  input  logic       en_i,
  input  logic [2:0] in_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = 8'h00;
    if (en_i) y_o[in_i] = 1'b1;
  end
endmodule

module rr_arbiter8 #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("rr_arbiter8: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;
  logic       release_now;
  logic       force_rel;

  // Search starts just after the last winner and wraps; offset 8 folds back onto ptr itself.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign release_now = done | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign force_rel = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = (state_q == ST_GRANT) ? cnt_q + 1'b1 : '0;
    timeout_d = (state_q == ST_GRANT) && !release_now && force_rel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 3'd7;
      gnt_id_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  // Next-state logic; the pointer only moves when a grant is issued
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_GRANT;
          ptr_d    = winner;
          gnt_id_d = winner;
        end
      end
      ST_GRANT: begin
        if (release_now || force_rel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q == ST_GRANT);
    gnt_id = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
    timeout = timeout_q;
`else
    timeout = 1'b0;
`endif
  end

  decoder3to8 u_dec (
    .en_i (busy),
    .in_i (gnt_id_q),
    .y_o  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected grant indices are queued as requests are
// driven and popped when the arbiter shows a grant.

module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  rr_arbiter8 dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, gnt, 8'h00);
    chk({tag, "_busy"}, {7'd0, busy}, 8'h00);
  endtask

  task automatic check_grant(input string tag);
    logic [2:0] e;
    logic [7:0] onehot;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'h01, 8'h00);
    end else begin
      e      = exp_q.pop_front();
      onehot = 8'h01 << e;
      chk({tag, "_busy"}, {7'd0, busy}, 8'h01);
      chk({tag, "_gnt_id"}, {5'd0, gnt_id}, {5'd0, e});
      chk({tag, "_gnt"}, gnt, onehot);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // 1: reset state then quiet idle
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_gnt_id", {5'd0, gnt_id}, 8'h00);
    chk("rst_timeout", {7'd0, timeout}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("quiet");
      chk("quiet_timeout", {7'd0, timeout}, 8'h00);
    end

    // 2: sole requester, done three cycles into tenure, then re-grant
    req = 8'h01;
    exp_q.push_back(3'd0);
    tick();
    check_grant("sole_first");
    tick();
    chk("sole_hold1", gnt, 8'h01);
    tick();
    chk("sole_hold2", gnt, 8'h01);
    done = 1'b1;
    tick();
    check_idle("sole_turnaround");
    done = 1'b0;
    exp_q.push_back(3'd0);
    tick();
    check_grant("sole_regrant");
    req = 8'h00;
    tick();
    check_idle("sole_withdraw");

    // Reset restores the pointer so requester 0 is first again
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // 3: all requesting, one-cycle tenures rotate 0..7,0
    req  = 8'hFF;
    done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(3'(k % 8));
      tick();
      check_grant("rotate");
      tick();
      check_idle("rotate_gap");
    end

    // 4: grant 4, then 0x90 alternates 7,4,7 with wrap
    req  = 8'h10;
    done = 1'b0;
    exp_q.push_back(3'd4);
    tick();
    check_grant("wrap_seed");
    req  = 8'h90;
    done = 1'b1;
    tick();
    check_idle("wrap_seed_gap");
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_grant("wrap");
      tick();
      check_idle("wrap_gap");
    end
    req  = 8'h00;
    done = 1'b0;

    // 5: owner 2 withdraws and signals done together -> one release
    req = 8'h24;
    exp_q.push_back(3'd2);
    tick();
    check_grant("both_rel_own");
    tick();
    chk("both_rel_hold", gnt, 8'h04);
    req  = 8'h20;
    done = 1'b1;
    tick();
    check_idle("both_rel_gap");
    done = 1'b0;
    exp_q.push_back(3'd5);
    tick();
    check_grant("both_rel_next");
    req = 8'h00;
    tick();
    check_idle("both_rel_end");

    // Reset mid-grant drops the grant at once and does not resume it
    req = 8'h40;
    exp_q.push_back(3'd6);
    tick();
    check_grant("midrst_own");
    reset = 1'b1;
    #1;
    check_idle("midrst_async");
    chk("midrst_gnt_id", {5'd0, gnt_id}, 8'h00);
    req = 8'h00;
    tick();
    reset = 1'b0;
    tick();
    check_idle("midrst_after1");
    tick();
    check_idle("midrst_after2");

    // 6: requester 3 never signals done
    req = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    check_grant("hold_first");
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("hold_gnt", gnt, 8'h08);
      chk("hold_timeout", {7'd0, timeout}, 8'h00);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    check_idle("evict");
    chk("evict_timeout", {7'd0, timeout}, 8'h01);
    exp_q.push_back(3'd3);
    tick();
    check_grant("evict_regrant");
    chk("evict_timeout_clear", {7'd0, timeout}, 8'h00);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("evict2_hold", gnt, 8'h08);
    end
    done = 1'b1;
    tick();
    check_idle("evict2_done_wins");
    chk("evict2_timeout", {7'd0, timeout}, 8'h00);
`else
    chk("persist_gnt", gnt, 8'h08);
    chk("persist_timeout", {7'd0, timeout}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("persist_more", gnt, 8'h08);
    end
    done = 1'b1;
    tick();
    check_idle("persist_release");
    chk("persist_release_timeout", {7'd0, timeout}, 8'h00);
`endif
    done = 1'b0;
    req  = 8'h00;
    tick();

    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
